dec38_seq: RTL and testbench

- Registered 3-to-8 decoder with handshake; the receiving end of the 8:3 priority encoder path.
- Accepts a 3-bit code plus valid (encoder o2..o0 and valid) and drives the matching one-hot line for a guaranteed minimum hold time.
- Optionally waits for a consumer acknowledge, with a timeout.
- Sits between the interrupt/request encoder and the per-line consumers.

---
 rtl/dec38_pkg.sv | 22 ++
 rtl/dec38_onehot.sv | 21 ++
 rtl/dec38_seq.sv | 125 ++++++++++++
 tb/tb_dec38_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dec38_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec38_pkg
//  Description : Shared types and sizes for the registered 3-to-8 decoder.
//                Holds the FSM state encoding, the code/line widths and the
//                counter width used by the hold and acknowledge counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package dec38_pkg;

  localparam int CODE_W = 3;   // width of the encoded index
  localparam int LINES  = 8;   // number of one-hot output lines
  localparam int CNT_W  = 8;   // hold / ack counters, sized for 255 maxima

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage : dec38_pkg
`default_nettype wire

// File: rtl/dec38_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : dec38_onehot
//  Description : Pure combinational 3-to-8 decoder.
//  Ports       : code   [CODE_W-1:0] in  - encoded index
//                onehot [LINES-1:0]  out - onehot[code] = 1, others 0
//  Revision    : 1.0 - initial release
// ============================================================================
module dec38_onehot
  import dec38_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  onehot
);

  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign onehot[i] = (code == CODE_W'(i));
  end

endmodule : dec38_onehot
`default_nettype wire

// File: rtl/dec38_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dec38_seq
//  Description : Registered 3-to-8 decoder with handshake. Accepts a code from
//                the priority encoder, drives the matching one-hot line for at
//                least HOLD_CYCLES cycles and optionally waits for a consumer
//                acknowledge, with a timeout that forces release.
//  Ports       : clk          in   - clock, rising edge
//                rst_n        in   - asynchronous active-low reset
//                in_valid     in   - code offered
//                in_code[2:0] in   - encoded index
//                in_ready     out  - block is IDLE and can accept
//                out_onehot   out  - registered one-hot line
//                out_valid    out  - high whenever out_onehot is non-zero
//                out_ack      in   - consumer acknowledge, level sampled
//                busy         out  - state != IDLE
//                timeout_err  out  - one-cycle pulse on forced release
//  Revision    : 1.0 - initial release
// ============================================================================
module dec38_seq
  import dec38_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,   // 1..255
  parameter int USE_ACK     = 1,   // 1 = wait for out_ack after the hold
  parameter int ACK_TIMEOUT = 16   // 0 disables the timeout, else 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINES-1:0]  out_onehot,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  // Guarded so that ACK_TIMEOUT = 0 does not wrap to an all-ones compare value.
  localparam logic [CNT_W-1:0] ACK_LAST  =
      CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic             ACK_EN    = (USE_ACK != 0);
  localparam logic             TMO_EN    = (ACK_TIMEOUT != 0);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] ack_cnt;
  logic             ack_seen;
  logic [LINES-1:0] dec_onehot;

  dec38_onehot u_onehot (
    .code   (in_code),
    .onehot (dec_onehot)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_onehot  <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      ack_cnt     <= '0;
      ack_seen    <= 1'b0;
    end else begin
      // timeout_err is a pulse: only the forced-release branch raises it.
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_onehot <= dec_onehot;
            out_valid  <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            ack_seen   <= 1'b0;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (out_ack) begin
            ack_seen <= 1'b1;
          end
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (!ACK_EN || ack_seen || out_ack) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end else begin
            ack_cnt <= '0;
            state   <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (out_ack) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end else if (TMO_EN && (ack_cnt == ACK_LAST)) begin
            out_onehot  <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        default: begin
          out_onehot <= '0;
          out_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule : dec38_seq
`default_nettype wire

// File: tb/tb_dec38_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec38_seq
//  Description : Directed self-checking bench for dec38_seq. Instance u_na runs
//                without acknowledge, u_ack runs with acknowledge and a
//                16-cycle timeout; both use a 4-cycle hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dec38_seq;

  logic       clk;
  logic       rst_n;

  logic       na_valid, na_ready, na_ovalid, na_ack, na_busy, na_terr;
  logic [2:0] na_code;
  logic [7:0] na_oh;

  logic       ak_valid, ak_ready, ak_ovalid, ak_ack, ak_busy, ak_terr;
  logic [2:0] ak_code;
  logic [7:0] ak_oh;

  int checks = 0;
  int errors = 0;

  dec38_seq #(.HOLD_CYCLES(4), .USE_ACK(0), .ACK_TIMEOUT(16)) u_na (
    .clk(clk), .rst_n(rst_n), .in_valid(na_valid), .in_code(na_code),
    .in_ready(na_ready), .out_onehot(na_oh), .out_valid(na_ovalid),
    .out_ack(na_ack), .busy(na_busy), .timeout_err(na_terr)
  );

  dec38_seq #(.HOLD_CYCLES(4), .USE_ACK(1), .ACK_TIMEOUT(16)) u_ack (
    .clk(clk), .rst_n(rst_n), .in_valid(ak_valid), .in_code(ak_code),
    .in_ready(ak_ready), .out_onehot(ak_oh), .out_valid(ak_ovalid),
    .out_ack(ak_ack), .busy(ak_busy), .timeout_err(ak_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a code to the ack instance for one edge; returns in HOLD cycle 0.
  task automatic ak_accept(input logic [2:0] code);
    ak_code  = code;
    ak_valid = 1'b1;
    tick();
    ak_valid = 1'b0;
  endtask

  logic [7:0] exp_oh;

  initial begin
    rst_n    = 1'b0;
    na_valid = 1'b0; na_code = 3'd0; na_ack = 1'b0;
    ak_valid = 1'b0; ak_code = 3'd0; ak_ack = 1'b0;

    // ---- reset then idle
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_oh",    {24'd0, na_oh},  32'h00);
      check("rst_valid", {31'd0, na_ovalid}, 32'd0);
      check("rst_busy",  {31'd0, ak_busy},  32'd0);
      check("rst_ready", {31'd0, ak_ready}, 32'd1);
      tick();
    end
    rst_n = 1'b1;
    tick();
    check("idle_oh",    {24'd0, ak_oh},    32'h00);
    check("idle_ready", {31'd0, na_ready}, 32'd1);
    check("idle_busy",  {31'd0, na_busy},  32'd0);

    // ---- no-ack: code 5 held exactly 4 cycles
    na_code = 3'd5; na_valid = 1'b1;
    tick();
    na_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("na5_oh",    {24'd0, na_oh},    32'h20);
      check("na5_ready", {31'd0, na_ready}, 32'd0);
      tick();
    end
    check("na5_rel_oh",    {24'd0, na_oh},     32'h00);
    check("na5_rel_valid", {31'd0, na_ovalid}, 32'd0);
    check("na5_rel_ready", {31'd0, na_ready},  32'd1);

    // ---- sweep 0..7 with in_valid held high; code wiggled during HOLD
    na_code = 3'd0; na_valid = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_oh = 8'h01 << k;
      for (int c = 0; c < 4; c++) begin
        check("sweep_oh", {24'd0, na_oh}, {24'd0, exp_oh});
        if (c == 1) na_code = ~na_code;  // must not disturb the accepted line
        tick();
      end
      check("sweep_gap", {24'd0, na_oh}, 32'h00);
      na_code = 3'(k + 1);
      tick();
    end
    na_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("sweep_end", {24'd0, na_oh}, 32'h00);

    // ---- ack: code 2, ack 7 cycles after rise -> 8 cycles high
    ak_accept(3'd2);
    for (int c = 0; c < 8; c++) begin
      check("ack2_oh",   {24'd0, ak_oh},   32'h04);
      check("ack2_terr", {31'd0, ak_terr}, 32'd0);
      if (c == 7) ak_ack = 1'b1;
      tick();
      ak_ack = 1'b0;
    end
    check("ack2_rel",  {24'd0, ak_oh},   32'h00);
    check("ack2_terr", {31'd0, ak_terr}, 32'd0);
    tick();

    // ---- ack pulsed during HOLD -> release exactly at 4 cycles
    ak_accept(3'd3);
    for (int c = 0; c < 4; c++) begin
      check("ackh_oh", {24'd0, ak_oh}, 32'h08);
      if (c == 1) ak_ack = 1'b1;
      tick();
      ak_ack = 1'b0;
    end
    check("ackh_rel", {24'd0, ak_oh}, 32'h00);
    tick();

    // ---- timeout: no ack -> 4 + 16 cycles, then one-cycle timeout_err
    ak_accept(3'd6);
    for (int c = 0; c < 20; c++) begin
      check("tmo_oh",   {24'd0, ak_oh},   32'h40);
      check("tmo_terr", {31'd0, ak_terr}, 32'd0);
      tick();
    end
    check("tmo_rel",    {24'd0, ak_oh},   32'h00);
    check("tmo_pulse",  {31'd0, ak_terr}, 32'd1);
    tick();
    check("tmo_pulse1", {31'd0, ak_terr}, 32'd0);
    check("tmo_ready",  {31'd0, ak_ready}, 32'd1);

    // ---- ack on the final WAIT_ACK cycle wins over the timeout
    ak_accept(3'd4);
    for (int c = 0; c < 20; c++) begin
      check("late_oh", {24'd0, ak_oh}, 32'h10);
      if (c == 19) ak_ack = 1'b1;
      tick();
      ak_ack = 1'b0;
    end
    check("late_rel",  {24'd0, ak_oh},   32'h00);
    check("late_terr", {31'd0, ak_terr}, 32'd0);
    tick();
    check("late_terr1", {31'd0, ak_terr}, 32'd0);

    // ---- ack while IDLE is ignored
    ak_ack = 1'b1;
    tick(); tick();
    ak_ack = 1'b0;
    check("idle_ack_busy", {31'd0, ak_busy}, 32'd0);
    check("idle_ack_oh",   {24'd0, ak_oh},   32'h00);

    // ---- asynchronous reset mid-HOLD
    ak_accept(3'd7);
    check("rsth_oh", {24'd0, ak_oh}, 32'h80);
    tick();
    rst_n = 1'b0;
    #1;
    check("rsth_async_oh", {24'd0, ak_oh},     32'h00);
    check("rsth_valid",    {31'd0, ak_ovalid}, 32'd0);
    check("rsth_busy",     {31'd0, ak_busy},   32'd0);
    check("rsth_terr",     {31'd0, ak_terr},   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rsth_after_terr", {31'd0, ak_terr}, 32'd0);
    ak_accept(3'd1);
    check("rsth_next_oh", {24'd0, ak_oh}, 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dec38_seq
`default_nettype wire
